// File: rtl/fifo_rd_ptr.sv
// Read-side pointer controller for a single-clock FIFO: owns the read address,
// derives occupancy/empty flags against the writer's pointer, and times read-data valid.
module fifo_rd_ptr #(
  parameter int ADDR_WIDTH = 4,
  parameter int AE_THRESH  = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  input  logic                  clr_err,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  rd_valid,
  output logic                  underflow,
  output logic                  ptr_err
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic                  underflow_q, underflow_d;
  logic                  ptr_err_q, ptr_err_d;
  logic                  accept;

  // Wrap bit makes full (count == DEPTH) distinct from empty (count == 0).
  assign count        = wr_ptr - rd_ptr_q;
  assign empty        = (count == '0);
  assign almost_empty = (count <= AE_C);
  assign accept       = rd_en & ~empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (accept) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    vld_d    = '0;
    vld_d[0] = accept;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    // Set takes priority over a same-cycle clear.
    underflow_d = (rd_en & empty) | (underflow_q & ~clr_err);
    ptr_err_d   = (count > DEPTH_C) | (ptr_err_q & ~clr_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      vld_q       <= '0;
      underflow_q <= 1'b0;
      ptr_err_q   <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      vld_q       <= vld_d;
      underflow_q <= underflow_d;
      ptr_err_q   <= ptr_err_d;
    end
  end

  assign rd_ptr    = rd_ptr_q;
  assign rd_addr   = rd_ptr_q[ADDR_WIDTH-1:0];
  assign rd_valid  = vld_q[RD_LATENCY-1];
  assign underflow = underflow_q;
  assign ptr_err   = ptr_err_q;

endmodule

// File: tb/tb_fifo_rd_ptr.sv
// Directed bench for fifo_rd_ptr: one instance at RD_LATENCY=1 and one at
// RD_LATENCY=3 driven by the same stimulus.
module tb_fifo_rd_ptr;

  logic       clk;
  logic       reset;
  logic       rd_en;
  logic [4:0] wr_ptr;
  logic       clr_err;

  logic [3:0] rd_addr, rd_addr3;
  logic [4:0] rd_ptr, rd_ptr3;
  logic [4:0] count, count3;
  logic       empty, empty3, almost_empty, almost_empty3;
  logic       rd_valid, rd_valid3, underflow, underflow3, ptr_err, ptr_err3;

  int checks = 0;
  int errors = 0;

  fifo_rd_ptr #(.ADDR_WIDTH(4), .AE_THRESH(2), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .wr_ptr(wr_ptr), .clr_err(clr_err),
    .rd_addr(rd_addr), .rd_ptr(rd_ptr), .count(count), .empty(empty),
    .almost_empty(almost_empty), .rd_valid(rd_valid), .underflow(underflow),
    .ptr_err(ptr_err)
  );

  fifo_rd_ptr #(.ADDR_WIDTH(4), .AE_THRESH(2), .RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .rd_en(rd_en), .wr_ptr(wr_ptr), .clr_err(clr_err),
    .rd_addr(rd_addr3), .rd_ptr(rd_ptr3), .count(count3), .empty(empty3),
    .almost_empty(almost_empty3), .rd_valid(rd_valid3), .underflow(underflow3),
    .ptr_err(ptr_err3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0; rd_en = 1'b0; wr_ptr = 5'd0; clr_err = 1'b0;

    // Asynchronous reset before any clock edge
    #3 reset = 1'b1;
    #1;
    chk("rst_rd_ptr",   32'(rd_ptr), 0);
    chk("rst_rd_addr",  32'(rd_addr), 0);
    chk("rst_empty",    32'(empty), 1);
    chk("rst_count",    32'(count), 0);
    chk("rst_ae",       32'(almost_empty), 1);
    chk("rst_valid",    32'(rd_valid), 0);
    chk("rst_valid3",   32'(rd_valid3), 0);
    chk("rst_uf",       32'(underflow), 0);
    chk("rst_perr",     32'(ptr_err), 0);
    @(negedge clk);
    reset = 1'b0;

    // Fill and drain: 5 entries, 6 requests
    wr_ptr = 5'd5; rd_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("fd_addr",  32'(rd_addr), (i < 5) ? i : 5);
      chk("fd_empty", 32'(empty), 32'(i == 5));
      chk("fd_valid", 32'(rd_valid), 32'(i >= 1));
      chk("fd_uf",    32'(underflow), 0);
      @(negedge clk);
    end
    #1;
    chk("fd_uf_set",  32'(underflow), 1);
    chk("fd_valid_end", 32'(rd_valid), 0);
    chk("fd_rd_ptr",  32'(rd_ptr), 5);
    rd_en = 1'b0; clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    #1;
    chk("fd_uf_clr", 32'(underflow), 0);

    // Wrap: 16 accepts from a full FIFO
    reset = 1'b1; #1 reset = 1'b0;
    wr_ptr = 5'b10000; rd_en = 1'b1;
    repeat (16) @(negedge clk);
    rd_en = 1'b0;
    #1;
    chk("wr_rd_ptr", 32'(rd_ptr), 32'h10);
    chk("wr_rd_addr", 32'(rd_addr), 0);
    chk("wr_empty",  32'(empty), 1);
    wr_ptr = 5'b10011;
    #1;
    chk("wr_count3", 32'(count), 3);
    chk("wr_empty3", 32'(empty), 0);
    chk("wr_ae3",    32'(almost_empty), 0);
    rd_en = 1'b1;
    @(negedge clk);
    #1;
    chk("wr_count2", 32'(count), 2);
    chk("wr_ae2",    32'(almost_empty), 1);
    @(negedge clk);
    @(negedge clk);
    rd_en = 1'b0;
    #1;
    chk("wr_empty_end", 32'(empty), 1);
    chk("wr_ptr_end",   32'(rd_ptr), 32'h13);
    chk("wr_uf",        32'(underflow), 0);

    // Full is not empty
    reset = 1'b1; #1 reset = 1'b0;
    wr_ptr = 5'b10000;
    #1;
    chk("full_count", 32'(count), 16);
    chk("full_empty", 32'(empty), 0);
    chk("full_ae",    32'(almost_empty), 0);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    #1;
    chk("full_count15", 32'(count), 15);
    chk("full_addr",    32'(rd_addr), 1);
    chk("full_perr",    32'(ptr_err), 0);

    // Simultaneous read and write on the last entry
    wr_ptr = 5'd2;
    #1;
    chk("sim_count1", 32'(count), 1);
    rd_en = 1'b1;
    @(negedge clk);
    wr_ptr = 5'd3; rd_en = 1'b0;
    #1;
    chk("sim_count", 32'(count), 1);
    chk("sim_empty", 32'(empty), 0);
    chk("sim_rd_ptr", 32'(rd_ptr), 2);

    // Underflow set wins over same-cycle clear
    wr_ptr = 5'd2;
    rd_en = 1'b1; clr_err = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    #1;
    chk("uf_setwins", 32'(underflow), 1);
    chk("uf_noptr",   32'(rd_ptr), 2);
    chk("uf_novalid", 32'(rd_valid), 0);
    @(negedge clk);
    clr_err = 1'b0;
    #1;
    chk("uf_cleared", 32'(underflow), 0);

    // Latency 3: single accept
    reset = 1'b1; #1 reset = 1'b0;
    wr_ptr = 5'd4; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    #1;
    chk("lat_v1_lat1", 32'(rd_valid), 1);
    chk("lat_v3_c1",   32'(rd_valid3), 0);
    @(negedge clk); #1;
    chk("lat_v3_c2",   32'(rd_valid3), 0);
    @(negedge clk); #1;
    chk("lat_v3_c3",   32'(rd_valid3), 1);
    @(negedge clk); #1;
    chk("lat_v3_c4",   32'(rd_valid3), 0);

    // Two accepts, then reset mid-flight
    rd_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rd_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("mf_v3_rst",  32'(rd_valid3), 0);
    chk("mf_ptr_rst", 32'(rd_ptr3), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mf_v3_quiet", 32'(rd_valid3), 0);
      chk("mf_v1_quiet", 32'(rd_valid), 0);
      @(negedge clk);
    end

    // Pointer corruption
    wr_ptr = 5'd20;
    #1;
    chk("pe_count", 32'(count), 20);
    chk("pe_before", 32'(ptr_err), 0);
    @(negedge clk);
    #1;
    chk("pe_set", 32'(ptr_err), 1);
    wr_ptr = 5'd0; clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    #1;
    chk("pe_clr", 32'(ptr_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
